// File: rtl/reg32_ad_pkg.sv
// Shared constants and types for the reg32_ad register bank.
// Holds the entry count, index width and default data width.
package reg32_ad_pkg;

    localparam int NUM_ENTRIES = 16;
    localparam int IDX_W       = 4;
    localparam int WIDTH       = 32;

    typedef logic [WIDTH-1:0] word_t;
    typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/reg32_ad_entry.sv
// One register-bank entry: a WIDTH-bit register with a synchronous
// active-high clear and a load enable.
module reg32_entry
    import reg32_ad_pkg::*;
#(
    parameter int WIDTH = reg32_ad_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // NOTE: non-blocking assignment for flop state, so every reader sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg32_ad.sv
// Sixteen-entry register bank: each entry captures only its own data_in<k> on
// an addressed write; a registered 16:1 read port drives the shared bus.
module reg32_ad
    import reg32_ad_pkg::*;
#(
    parameter int WIDTH = reg32_ad_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write_en,
    input  logic [3:0]       write_line,
    input  logic             read_en,
    input  logic [3:0]       read_line,
    input  logic [WIDTH-1:0] data_in0,
    input  logic [WIDTH-1:0] data_in1,
    input  logic [WIDTH-1:0] data_in2,
    input  logic [WIDTH-1:0] data_in3,
    input  logic [WIDTH-1:0] data_in4,
    input  logic [WIDTH-1:0] data_in5,
    input  logic [WIDTH-1:0] data_in6,
    input  logic [WIDTH-1:0] data_in7,
    input  logic [WIDTH-1:0] data_in8,
    input  logic [WIDTH-1:0] data_in9,
    input  logic [WIDTH-1:0] data_in10,
    input  logic [WIDTH-1:0] data_in11,
    input  logic [WIDTH-1:0] data_in12,
    input  logic [WIDTH-1:0] data_in13,
    input  logic [WIDTH-1:0] data_in14,
    input  logic [WIDTH-1:0] data_in15,
    output logic [WIDTH-1:0] data_out0,
    output logic [WIDTH-1:0] data_out1,
    output logic [WIDTH-1:0] data_out2,
    output logic [WIDTH-1:0] data_out3,
    output logic [WIDTH-1:0] data_out4,
    output logic [WIDTH-1:0] data_out5,
    output logic [WIDTH-1:0] data_out6,
    output logic [WIDTH-1:0] data_out7,
    output logic [WIDTH-1:0] data_out8,
    output logic [WIDTH-1:0] data_out9,
    output logic [WIDTH-1:0] data_out10,
    output logic [WIDTH-1:0] data_out11,
    output logic [WIDTH-1:0] data_out12,
    output logic [WIDTH-1:0] data_out13,
    output logic [WIDTH-1:0] data_out14,
    output logic [WIDTH-1:0] data_out15,
    output logic [WIDTH-1:0] data_out_bus
);

    logic [WIDTH-1:0]       din   [NUM_ENTRIES];
    logic [WIDTH-1:0]       q     [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] load;
    logic [WIDTH-1:0]       rd_word;
    idx_t                   wr_idx;
    idx_t                   rd_idx;

    assign wr_idx = write_line;
    assign rd_idx = read_line;

    assign din[0]  = data_in0;
    assign din[1]  = data_in1;
    assign din[2]  = data_in2;
    assign din[3]  = data_in3;
    assign din[4]  = data_in4;
    assign din[5]  = data_in5;
    assign din[6]  = data_in6;
    assign din[7]  = data_in7;
    assign din[8]  = data_in8;
    assign din[9]  = data_in9;
    assign din[10] = data_in10;
    assign din[11] = data_in11;
    assign din[12] = data_in12;
    assign din[13] = data_in13;
    assign din[14] = data_in14;
    assign din[15] = data_in15;

    // write_en gates the decode, so an unknown write_line while idle loads nothing.
    for (genvar k = 0; k < NUM_ENTRIES; k++) begin : g_entry
        assign load[k] = write_en & (wr_idx == idx_t'(k));

        reg32_entry #(.WIDTH(WIDTH)) u_entry (
            .clk   (clk),
            .reset (reset),
            .load  (load[k]),
            .d     (din[k]),
            .q     (q[k])
        );
    end

    assign data_out0  = q[0];
    assign data_out1  = q[1];
    assign data_out2  = q[2];
    assign data_out3  = q[3];
    assign data_out4  = q[4];
    assign data_out5  = q[5];
    assign data_out6  = q[6];
    assign data_out7  = q[7];
    assign data_out8  = q[8];
    assign data_out9  = q[9];
    assign data_out10 = q[10];
    assign data_out11 = q[11];
    assign data_out12 = q[12];
    assign data_out13 = q[13];
    assign data_out14 = q[14];
    assign data_out15 = q[15];

    // NOTE: default assignment first so the combinational mux never infers a latch.
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NUM_ENTRIES; k++) begin
            if (rd_idx == idx_t'(k)) begin
                rd_word = q[k];
            end
        end
    end

    // The mux sees pre-edge entry values, giving read-before-write on a shared edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_bus <= '0;
        end else if (read_en) begin
            data_out_bus <= rd_word;
        end
    end

endmodule

// File: tb/tb_reg32_ad.sv
// Self-checking bench for reg32_ad: a bench-side model of the bank feeds a
// scoreboard queue of expected bus reads, popped one cycle after each request.
module tb_reg32_ad;

    logic        clk;
    logic        reset;
    logic        write_en;
    logic [3:0]  write_line;
    logic        read_en;
    logic [3:0]  read_line;
    logic [31:0] din  [16];
    logic [31:0] dout [16];
    logic [31:0] data_out_bus;

    logic [31:0] model [16];
    logic [31:0] bus_model;
    logic [31:0] sb_q [$];

    int n_checks = 0;
    int n_pass   = 0;

    reg32_ad dut (
        .clk          (clk),
        .reset        (reset),
        .write_en     (write_en),
        .write_line   (write_line),
        .read_en      (read_en),
        .read_line    (read_line),
        .data_in0     (din[0]),
        .data_in1     (din[1]),
        .data_in2     (din[2]),
        .data_in3     (din[3]),
        .data_in4     (din[4]),
        .data_in5     (din[5]),
        .data_in6     (din[6]),
        .data_in7     (din[7]),
        .data_in8     (din[8]),
        .data_in9     (din[9]),
        .data_in10    (din[10]),
        .data_in11    (din[11]),
        .data_in12    (din[12]),
        .data_in13    (din[13]),
        .data_in14    (din[14]),
        .data_in15    (din[15]),
        .data_out0    (dout[0]),
        .data_out1    (dout[1]),
        .data_out2    (dout[2]),
        .data_out3    (dout[3]),
        .data_out4    (dout[4]),
        .data_out5    (dout[5]),
        .data_out6    (dout[6]),
        .data_out7    (dout[7]),
        .data_out8    (dout[8]),
        .data_out9    (dout[9]),
        .data_out10   (dout[10]),
        .data_out11   (dout[11]),
        .data_out12   (dout[12]),
        .data_out13   (dout[13]),
        .data_out14   (dout[14]),
        .data_out15   (dout[15]),
        .data_out_bus (data_out_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the model with the currently driven inputs, then take one edge.
    task automatic cycle();
        if (reset) begin
            for (int k = 0; k < 16; k++) model[k] = '0;
            bus_model = '0;
        end else begin
            if (read_en) begin
                sb_q.push_back(model[read_line]);
                bus_model = model[read_line];
            end
            if (write_en) model[write_line] = din[write_line];
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        write_en   = 1'b1;
        write_line = 4'd2;
        din[2]     = 32'h0000_FFFF;
        cycle();
        cycle();
        reset    = 1'b0;
        write_en = 1'b0;
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (dout[k] !== 32'h0) $display("FAIL reset_entry%0d: got %h expected %h", k, dout[k], 32'h0);
            else n_pass++;
        end
        n_checks++;
        if (data_out_bus !== 32'h0) $display("FAIL reset_bus: got %h expected %h", data_out_bus, 32'h0);
        else n_pass++;
    endtask

    task automatic test_single_write();
        write_line = 4'd2;
        din[2]     = 32'h0000_FFFF;
        write_en   = 1'b1;
        cycle();
        write_en = 1'b0;
        din[2]   = 32'hDEAD_0000;
        n_checks++;
        if (dout[2] !== 32'h0000_FFFF) $display("FAIL single_write_e2: got %h expected %h", dout[2], 32'h0000_FFFF);
        else n_pass++;
        cycle();
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (dout[k] !== model[k]) $display("FAIL single_write_entry%0d: got %h expected %h", k, dout[k], model[k]);
            else n_pass++;
        end
    endtask

    task automatic test_select_isolation();
        write_line = 4'd5;
        din[5]     = 32'hA5A5_A5A5;
        din[6]     = 32'h1234_5678;
        write_en   = 1'b1;
        cycle();
        write_en = 1'b0;
        n_checks++;
        if (dout[5] !== 32'hA5A5_A5A5) $display("FAIL isolate_e5: got %h expected %h", dout[5], 32'hA5A5_A5A5);
        else n_pass++;
        n_checks++;
        if (dout[6] !== 32'h0) $display("FAIL isolate_e6: got %h expected %h", dout[6], 32'h0);
        else n_pass++;
        din[5] = 32'h5A5A_5A5A;
        cycle();
        n_checks++;
        if (dout[5] !== 32'hA5A5_A5A5) $display("FAIL hold_e5: got %h expected %h", dout[5], 32'hA5A5_A5A5);
        else n_pass++;
        // Unknown write index while idle must not disturb any entry.
        write_line = 4'bxxxx;
        for (int k = 0; k < 16; k++) din[k] = 32'hFFFF_0000 | k;
        cycle();
        write_line = 4'd0;
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (dout[k] !== model[k]) $display("FAIL idle_x_entry%0d: got %h expected %h", k, dout[k], model[k]);
            else n_pass++;
        end
    endtask

    task automatic test_read_port();
        logic [31:0] exp;
        write_en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            write_line = 4'(k);
            din[k]     = 32'h1000_0000 + k;
            cycle();
        end
        write_en = 1'b0;
        read_en  = 1'b1;
        for (int k = 0; k < 16; k++) begin
            read_line = 4'(k);
            cycle();
            n_checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL read_sweep%0d: scoreboard empty", k);
            end else begin
                exp = sb_q.pop_front();
                if (data_out_bus !== exp || exp !== 32'h1000_0000 + k)
                    $display("FAIL read_sweep%0d: got %h expected %h", k, data_out_bus, 32'h1000_0000 + k);
                else n_pass++;
            end
        end
        read_en   = 1'b0;
        read_line = 4'd3;
        cycle();
        cycle();
        n_checks++;
        if (data_out_bus !== 32'h1000_000F) $display("FAIL read_hold: got %h expected %h", data_out_bus, 32'h1000_000F);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        write_en   = 1'b1;
        write_line = 4'd3;
        din[3]     = 32'hCAFE_0001;
        cycle();
        n_checks++;
        if (dout[3] !== 32'hCAFE_0001) $display("FAIL b2b_first: got %h expected %h", dout[3], 32'hCAFE_0001);
        else n_pass++;
        din[3] = 32'hCAFE_0002;
        cycle();
        write_en = 1'b0;
        n_checks++;
        if (dout[3] !== 32'hCAFE_0002) $display("FAIL b2b_second: got %h expected %h", dout[3], 32'hCAFE_0002);
        else n_pass++;
    endtask

    task automatic test_same_cycle();
        logic [31:0] exp;
        write_en   = 1'b1;
        write_line = 4'd7;
        din[7]     = 32'h1;
        cycle();
        din[7]    = 32'h2;
        read_en   = 1'b1;
        read_line = 4'd7;
        cycle();
        write_en = 1'b0;
        n_checks++;
        if (sb_q.size() == 0) begin
            $display("FAIL rbw_bus: scoreboard empty");
        end else begin
            exp = sb_q.pop_front();
            if (data_out_bus !== exp || exp !== 32'h1) $display("FAIL rbw_bus: got %h expected %h", data_out_bus, 32'h1);
            else n_pass++;
        end
        n_checks++;
        if (dout[7] !== 32'h2) $display("FAIL rbw_entry: got %h expected %h", dout[7], 32'h2);
        else n_pass++;
        cycle();
        read_en = 1'b0;
        n_checks++;
        if (sb_q.size() == 0) begin
            $display("FAIL rbw_reread: scoreboard empty");
        end else begin
            exp = sb_q.pop_front();
            if (data_out_bus !== exp || exp !== 32'h2) $display("FAIL rbw_reread: got %h expected %h", data_out_bus, 32'h2);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp;
        reset      = 1'b1;
        write_en   = 1'b1;
        read_en    = 1'b1;
        write_line = 4'd9;
        read_line  = 4'd9;
        din[9]     = 32'h9999_9999;
        cycle();
        reset    = 1'b0;
        write_en = 1'b0;
        read_en  = 1'b0;
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (dout[k] !== 32'h0) $display("FAIL mid_reset_entry%0d: got %h expected %h", k, dout[k], 32'h0);
            else n_pass++;
        end
        n_checks++;
        if (data_out_bus !== bus_model) $display("FAIL mid_reset_bus: got %h expected %h", data_out_bus, bus_model);
        else n_pass++;
        // First edge after reset accepts a write, the next a read of it.
        write_en = 1'b1;
        din[9]   = 32'h0BAD_F00D;
        cycle();
        write_en = 1'b0;
        read_en  = 1'b1;
        cycle();
        read_en = 1'b0;
        n_checks++;
        if (sb_q.size() == 0) begin
            $display("FAIL resume_read: scoreboard empty");
        end else begin
            exp = sb_q.pop_front();
            if (data_out_bus !== exp || exp !== 32'h0BAD_F00D)
                $display("FAIL resume_read: got %h expected %h", data_out_bus, 32'h0BAD_F00D);
            else n_pass++;
        end
    endtask

    initial begin
        reset      = 1'b1;
        write_en   = 1'b0;
        write_line = 4'd0;
        read_en    = 1'b0;
        read_line  = 4'd0;
        for (int k = 0; k < 16; k++) begin
            din[k]   = '0;
            model[k] = '0;
        end
        bus_model = '0;

        test_reset();
        test_single_write();
        test_select_isolation();
        test_read_port();
        test_back_to_back();
        test_same_cycle();
        test_reset_mid();

        n_checks++;
        if (sb_q.size() != 0) $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        else n_pass++;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
